pal_cpu_port: RTL and testbench
===============================

# pal_cpu_port

Palette RAM writer/arbiter. Accepts 68000 bus cycles to the palette window and splits each 16-bit word access into two byte accesses on the 8-bit, 13-bit-address palette RAM port. It shares that port with the video lookup path, and video always has priority. The block generates nDTACK and sits between the CPU address decoder and `pal_ram`.

## Interface
Parameters:
- RAM_AW, 13, palette RAM byte address width.
- RAM_DW, 8, palette RAM data width.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  reset, synchronous and active-high.
- PAL_CS  in  1  decoded palette window select, already synchronous to clk.
- nAS  in  1  68k address strobe, synchronised, active low.
- nUDS  in  1  upper data strobe, active low; selects the even (high) byte.
- nLDS  in  1  lower data strobe, active low; selects the odd (low) byte.
- RW  in  1  1 = read, 0 = write.
- CPU_ADDR  in  12  68k word address A[12:1].
- CPU_DIN  in  16  68k write data.
- CPU_DOUT  out  16  read data, held until the next read completes.
- nDTACK  out  1  data acknowledge, active low.
- VID_EN  in  1  video slot request for this cycle; PACLK rate, clk-synchronous.
- VID_ADDR  in  13  video lookup address {pal, color}.
- RAM_ADDR  out  13  registered RAM address.
- RAM_WE  out  1  registered RAM write enable.
- RAM_DIN  out  8  registered RAM write data.
- RAM_DOUT  in  8  RAM read data, valid 1 clk after RAM_ADDR.

## Operation
- Byte address mapping: high byte goes to {CPU_ADDR,1'b0} and low byte to {CPU_ADDR,1'b1}.
- States: IDLE, HI, LO, CAP, ACK.
- IDLE → HI when PAL_CS=1 and nAS=0. Latch RW, strobes, CPU_ADDR and CPU_DIN on this transition.
- HI issues the high-byte access if nUDS=0, otherwise it is skipped. Then → LO.
- LO issues the low-byte access if nLDS=0, otherwise it is skipped. Then → CAP on a read, or → ACK on a write.
- CAP waits for the last outstanding read byte to be captured, then → ACK.
- ACK holds nDTACK=0 until nAS=1, then nDTACK=1 and → IDLE.
- Stall: if VID_EN=1, the RAM port carries VID_ADDR with RAM_WE=0, and HI/LO do not advance. The CPU access is retried on the next cycle with VID_EN=0.
- Capture: a 2-bit issued tag (none/hi/lo), registered alongside RAM_ADDR, selects which CPU_DOUT byte loads from RAM_DOUT on the next cycle. Video-issued cycles never load CPU_DOUT.
- Skipped-lane bytes of CPU_DOUT keep their previous value.
- PAL_CS dropping mid-cycle has no effect. The latched access always completes.

## Timing
- Reset values: nDTACK=1, RAM_WE=0, RAM_ADDR=0, RAM_DIN=0, CPU_DOUT=0, state=IDLE.
- Reset asserted mid-access aborts at once. Bytes already written stay written, and no further write is issued.
- Word write with no stalls:
  - cycle 1: HI, RAM_WE=1.
  - cycle 2: LO, RAM_WE=1.
  - cycle 3: nDTACK=0.
- Word read with no stalls:
  - cycle 1: HI issue.
  - cycle 2: LO issue, high byte captured.
  - cycle 3: low byte captured.
  - cycle 4: nDTACK=0.
- Each VID_EN cycle during HI/LO adds exactly 1 clk of latency.
- RAM_WE is asserted only in a cycle where VID_EN was 0 and the state was HI or LO with the corresponding strobe active.
- No back-to-back accesses without nAS deasserting between them.

## Configuration
- PAL_READBACK_EN defined: reads behave as above.
- PAL_READBACK_EN undefined: reads skip all RAM access and go IDLE → ACK in 1 clk with CPU_DOUT=16'hFFFF. The CAP state and the capture logic are removed.

## Structure
- Shared package `pal_pkg`:
  - state enum;
  - issued-tag enum;
  - RAM_AW, RAM_DW;
  - READBACK_FILL=16'hFFFF.
- Sub-module `pal_port_arb` handles the registered RAM port mux: video-versus-CPU select, RAM_WE gating and the issued tag.
- The state machine stays in `pal_cpu_port`.

## Test plan
- Word write: CPU_ADDR=12'h123, CPU_DIN=16'hBEEF, both strobes, VID_EN=0 → RAM writes 0x0246=BE then 0x0247=EF; nDTACK low on cycle 3 and high 1 clk after nAS rises.
- Byte write: nLDS only, CPU_DIN=16'h12AB → a single write 0x0247=AB, nDTACK low on cycle 3; RAM at 0x0246 unchanged.
- Read-back (macro on): RAM[0x0246]=5A, RAM[0x0247]=C3 → CPU_DOUT=16'h5AC3 and nDTACK low on cycle 4.
- Video priority: VID_EN=1 for 3 clks during a word write → RAM_ADDR shows VID_ADDR with RAM_WE=0 for those cycles; nDTACK is delayed by exactly 3 clks and the data is still correct.
- Reset mid-write, asserted in the LO cycle → no RAM_WE after reset, nDTACK=1, state IDLE, only 0x0246 written.
- Macro off: read → nDTACK low 1 clk after start with CPU_DOUT=16'hFFFF, and no CPU-issued RAM cycles.

Source files
------------

// File: rtl/pal_pkg.sv
// -----------------------------------------------------------------------------
// pal_pkg
// Shared types and constants for the palette RAM CPU port.
//   - pal_state_e : CPU bus-cycle sequencer states
//   - pal_tag_e   : which CPU read byte (if any) the RAM port issued last cycle
//   - RAM_AW/RAM_DW : palette RAM byte address / data width
//   - READBACK_FILL : value returned on reads when RAM read-back is compiled out
// -----------------------------------------------------------------------------
package pal_pkg;

    localparam int          RAM_AW        = 13;
    localparam int          RAM_DW        = 8;
    localparam logic [15:0] READBACK_FILL = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_CAP  = 3'd3,
        ST_ACK  = 3'd4
    } pal_state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_HI   = 2'd1,
        TAG_LO   = 2'd2
    } pal_tag_e;

endpackage

// File: rtl/pal_port_arb.sv
// -----------------------------------------------------------------------------
// pal_port_arb
// Registered palette RAM port mux. Video always wins the port; a CPU byte
// access is only placed on the port in a cycle with no video request.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   vid_en, vid_addr    : video lookup request and address for this cycle
//   cpu_req             : CPU byte access wanted this cycle
//   cpu_rd              : 1 = read, 0 = write
//   cpu_lane_lo         : 1 = low (odd) byte, 0 = high (even) byte
//   cpu_addr, cpu_wdata : CPU byte address and write data
//   ram_addr/ram_we/ram_din : registered RAM port
//   issued_tag          : CPU read byte issued alongside ram_addr (pal_tag_e)
// -----------------------------------------------------------------------------
module pal_port_arb #(
    parameter int RAM_AW = 13,
    parameter int RAM_DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_en,
    input  logic [RAM_AW-1:0] vid_addr,
    input  logic              cpu_req,
    input  logic              cpu_rd,
    input  logic              cpu_lane_lo,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [RAM_DW-1:0] cpu_wdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [RAM_DW-1:0] ram_din,
    output logic [1:0]        issued_tag
);
    import pal_pkg::*;

    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [RAM_DW-1:0] ram_din_q,  ram_din_d;
    logic              ram_we_q,   ram_we_d;
    pal_tag_e          tag_q,      tag_d;

    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        tag_d      = TAG_NONE;
        if (vid_en) begin
            // Video lookups are read-only and never tagged, so they can
            // never land in CPU_DOUT.
            ram_addr_d = vid_addr;
        end else if (cpu_req) begin
            ram_addr_d = cpu_addr;
            ram_din_d  = cpu_wdata;
            ram_we_d   = ~cpu_rd;
            if (cpu_rd) begin
                tag_d = cpu_lane_lo ? TAG_LO : TAG_HI;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            tag_q      <= TAG_NONE;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            tag_q      <= tag_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_din    = ram_din_q;
    assign issued_tag = tag_q;

endmodule

// File: rtl/pal_cpu_port.sv
// -----------------------------------------------------------------------------
// pal_cpu_port
// Palette RAM writer/arbiter. Turns one 68000 word bus cycle in the palette
// window into up to two byte accesses (high byte at {A,0}, low byte at {A,1})
// on the shared 8-bit palette RAM port, yields to video every cycle VID_EN is
// high, and generates nDTACK.
// Optional feature macro: PAL_READBACK_EN
//   defined   : reads fetch both lanes from RAM into CPU_DOUT
//   undefined : reads touch no RAM and return 16'hFFFF after 1 clk
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   PAL_CS, nAS, nUDS, nLDS, RW: 68k bus cycle qualifiers (synchronised)
//   CPU_ADDR, CPU_DIN          : word address A[12:1], write data
//   CPU_DOUT, nDTACK           : read data (held), data acknowledge
//   VID_EN, VID_ADDR           : video lookup slot request and address
//   RAM_ADDR/RAM_WE/RAM_DIN    : registered palette RAM port
//   RAM_DOUT                   : RAM read data, valid 1 clk after RAM_ADDR
//   dbg_state                  : current sequencer state (pal_state_e)
// -----------------------------------------------------------------------------
module pal_cpu_port #(
    parameter int RAM_AW = 13,
    parameter int RAM_DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PAL_CS,
    input  logic              nAS,
    input  logic              nUDS,
    input  logic              nLDS,
    input  logic              RW,
    input  logic [11:0]       CPU_ADDR,
    input  logic [15:0]       CPU_DIN,
    output logic [15:0]       CPU_DOUT,
    output logic              nDTACK,
    input  logic              VID_EN,
    input  logic [RAM_AW-1:0] VID_ADDR,
    output logic [RAM_AW-1:0] RAM_ADDR,
    output logic              RAM_WE,
    output logic [RAM_DW-1:0] RAM_DIN,
    input  logic [RAM_DW-1:0] RAM_DOUT,
    output logic [2:0]        dbg_state
);
    import pal_pkg::*;

    pal_state_e  state_q,   state_d;
    logic        rw_q,      rw_d;
    logic        uds_n_q,   uds_n_d;
    logic        lds_n_q,   lds_n_d;
    logic [11:0] addr_q,    addr_d;
    logic [15:0] din_q,     din_d;
    logic [15:0] dout_q,    dout_d;
    logic        dtack_n_q, dtack_n_d;

    logic              cpu_req;
    logic              cpu_lane_lo;
    logic [RAM_AW-1:0] cpu_addr;
    logic [RAM_DW-1:0] cpu_wdata;

`ifdef PAL_READBACK_EN
    logic [1:0] tag_q;
`else
    logic [1:0] unused_tag;
    logic       unused_ram_dout;
    assign unused_ram_dout = ^RAM_DOUT;
`endif

    // A lane is issued from its own state; a skipped lane still spends the
    // state's cycle so word and byte accesses share the same timing.
    assign cpu_lane_lo = (state_q == ST_LO);
    assign cpu_req     = ((state_q == ST_HI) && !uds_n_q) ||
                         ((state_q == ST_LO) && !lds_n_q);
    assign cpu_addr    = {addr_q, cpu_lane_lo};
    assign cpu_wdata   = cpu_lane_lo ? din_q[7:0] : din_q[15:8];

    pal_port_arb #(
        .RAM_AW (RAM_AW),
        .RAM_DW (RAM_DW)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .vid_en      (VID_EN),
        .vid_addr    (VID_ADDR),
        .cpu_req     (cpu_req),
        .cpu_rd      (rw_q),
        .cpu_lane_lo (cpu_lane_lo),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .ram_addr    (RAM_ADDR),
        .ram_we      (RAM_WE),
        .ram_din     (RAM_DIN),
`ifdef PAL_READBACK_EN
        .issued_tag  (tag_q)
`else
        .issued_tag  (unused_tag)
`endif
    );

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        uds_n_d   = uds_n_q;
        lds_n_d   = lds_n_q;
        addr_d    = addr_q;
        din_d     = din_q;
        dout_d    = dout_q;
        dtack_n_d = dtack_n_q;

        case (state_q)
            ST_IDLE: begin
                dtack_n_d = 1'b1;
                if (PAL_CS && !nAS) begin
                    // Everything is latched here so later PAL_CS/bus changes
                    // cannot disturb the access in flight.
                    rw_d    = RW;
                    uds_n_d = nUDS;
                    lds_n_d = nLDS;
                    addr_d  = CPU_ADDR;
                    din_d   = CPU_DIN;
`ifdef PAL_READBACK_EN
                    state_d = ST_HI;
`else
                    if (RW) begin
                        state_d = ST_ACK;
                        dout_d  = READBACK_FILL;
                    end else begin
                        state_d = ST_HI;
                    end
`endif
                end
            end
            ST_HI: begin
                if (!VID_EN) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (!VID_EN) begin
`ifdef PAL_READBACK_EN
                    state_d = rw_q ? ST_CAP : ST_ACK;
`else
                    state_d = ST_ACK;
`endif
                end
            end
`ifdef PAL_READBACK_EN
            ST_CAP: begin
                // The low-lane tag issued on entry is consumed on this edge,
                // so every outstanding byte is in CPU_DOUT when ACK starts.
                state_d = ST_ACK;
            end
`endif
            ST_ACK: begin
                if (nAS) begin
                    dtack_n_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    dtack_n_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PAL_READBACK_EN
        // The tag travels with RAM_ADDR, so RAM_DOUT this cycle belongs to it.
        case (tag_q)
            TAG_HI:  dout_d[15:8] = RAM_DOUT;
            TAG_LO:  dout_d[7:0]  = RAM_DOUT;
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rw_q      <= 1'b1;
            uds_n_q   <= 1'b1;
            lds_n_q   <= 1'b1;
            addr_q    <= '0;
            din_q     <= '0;
            dout_q    <= '0;
            dtack_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            uds_n_q   <= uds_n_d;
            lds_n_q   <= lds_n_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            dout_q    <= dout_d;
            dtack_n_q <= dtack_n_d;
        end
    end

    assign CPU_DOUT  = dout_q;
    assign nDTACK    = dtack_n_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pal_cpu_port.sv
`timescale 1ns/1ps
module tb_pal_cpu_port;
    import pal_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PAL_CS = 1'b0;
    logic        nAS = 1'b1;
    logic        nUDS = 1'b1;
    logic        nLDS = 1'b1;
    logic        RW = 1'b1;
    logic [11:0] CPU_ADDR = '0;
    logic [15:0] CPU_DIN = '0;
    logic [15:0] CPU_DOUT;
    logic        nDTACK;
    logic        VID_EN = 1'b0;
    logic [12:0] VID_ADDR = '0;
    logic [12:0] RAM_ADDR;
    logic        RAM_WE;
    logic [7:0]  RAM_DIN;
    logic [7:0]  RAM_DOUT;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    pal_cpu_port dut (
        .clk       (clk),
        .reset     (reset),
        .PAL_CS    (PAL_CS),
        .nAS       (nAS),
        .nUDS      (nUDS),
        .nLDS      (nLDS),
        .RW        (RW),
        .CPU_ADDR  (CPU_ADDR),
        .CPU_DIN   (CPU_DIN),
        .CPU_DOUT  (CPU_DOUT),
        .nDTACK    (nDTACK),
        .VID_EN    (VID_EN),
        .VID_ADDR  (VID_ADDR),
        .RAM_ADDR  (RAM_ADDR),
        .RAM_WE    (RAM_WE),
        .RAM_DIN   (RAM_DIN),
        .RAM_DOUT  (RAM_DOUT),
        .dbg_state (dbg_state)
    );

    // Palette RAM stand-in: registered address in, data visible the cycle after.
    logic [7:0] phys_mem [0:8191];
    always @(posedge clk) if (RAM_WE) phys_mem[RAM_ADDR] <= RAM_DIN;
    assign RAM_DOUT = phys_mem[RAM_ADDR];

    // ---------------- reference model / scoreboard ----------------
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  model_mem [int];   // byte address -> expected RAM content
    logic [11:0] words [$];         // word addresses with both bytes known
    logic [15:0] exp_dout = 16'h0000;
    logic [28:0] exp_q [$];         // {sample index, RAM address, data}
    logic [28:0] obs_q [$];

    // One complete 68k bus cycle. Stalls are VID_EN cycles placed while the
    // sequencer is still on the high byte; each adds one clock.
    task automatic do_access(input logic rw, input logic uds_n, input logic lds_n,
                             input logic [11:0] a, input logic [15:0] d,
                             input int stalls, input string name);
        int          lat;
        int          exp_lat;
        bit          got;
        bit          drop_cs;
        logic        vid_prev;
        logic [12:0] vaddr_prev;
        logic [12:0] addr_at_start;
        exp_q.delete();
        obs_q.delete();
        exp_lat = 0;
        if (!rw) begin
            exp_lat = 3 + stalls;
            if (!uds_n) exp_q.push_back({8'(2 + stalls), a, 1'b0, d[15:8]});
            if (!lds_n) exp_q.push_back({8'(3 + stalls), a, 1'b1, d[7:0]});
        end else begin
`ifdef PAL_READBACK_EN
            exp_lat = 4 + stalls;
            if (!uds_n) exp_dout[15:8] = model_mem[int'({a, 1'b0})];
            if (!lds_n) exp_dout[7:0]  = model_mem[int'({a, 1'b1})];
`else
            exp_lat  = 1;
            exp_dout = 16'hFFFF;
`endif
        end

        drop_cs = bit'($urandom_range(0, 1));
        @(negedge clk);
        addr_at_start = RAM_ADDR;
        PAL_CS = 1'b1; nAS = 1'b0; RW = rw; nUDS = uds_n; nLDS = lds_n;
        CPU_ADDR = a; CPU_DIN = d; VID_EN = 1'b0;
        vid_prev = 1'b0; vaddr_prev = '0; got = 0; lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (vid_prev) begin
                n_cmp++;
                if (RAM_ADDR !== vaddr_prev || RAM_WE !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s video_slot k=%0d: got addr %h we %b, exp addr %h we 0",
                             name, k, RAM_ADDR, RAM_WE, vaddr_prev);
                end
            end
            if (RAM_WE === 1'b1) obs_q.push_back({8'(k), RAM_ADDR, RAM_DIN});
            if (nDTACK === 1'b0) begin
                lat = k - 1;
                got = 1;
                break;
            end
            if (k == 1 && drop_cs) PAL_CS = 1'b0;
            vid_prev   = (k <= stalls);
            VID_EN     = vid_prev;
            VID_ADDR   = 13'($urandom);
            vaddr_prev = VID_ADDR;
        end
        VID_EN = 1'b0;

        n_cmp++;
        if (!got || lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s dtack_latency: got %0d (seen=%0d), exp %0d", name, lat, got, exp_lat);
        end
        if (rw) begin
            n_cmp++;
            if (CPU_DOUT !== exp_dout) begin
                n_fail++;
                $display("FAIL %s cpu_dout: got %h, exp %h", name, CPU_DOUT, exp_dout);
            end
`ifndef PAL_READBACK_EN
            n_cmp++;
            if (RAM_ADDR !== addr_at_start) begin
                n_fail++;
                $display("FAIL %s no_cpu_ram_cycle: addr got %h, exp %h", name, RAM_ADDR, addr_at_start);
            end
`endif
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d, exp %0d", name, obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL %s write[%0d] {k,addr,data}: got %h, exp %h", name, i, obs_q[i], exp_q[i]);
                end
            end
        end

        nAS = 1'b1; PAL_CS = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (nDTACK !== 1'b1 || dbg_state !== 3'(ST_IDLE)) begin
            n_fail++;
            $display("FAIL %s release: got ndtack %b state %0d, exp 1 / %0d",
                     name, nDTACK, dbg_state, 3'(ST_IDLE));
        end

        if (!rw) begin
            if (!uds_n) model_mem[int'({a, 1'b0})] = d[15:8];
            if (!lds_n) model_mem[int'({a, 1'b1})] = d[7:0];
            if (!uds_n && !lds_n) words.push_back(a);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (nDTACK !== 1'b1 || RAM_WE !== 1'b0 || RAM_ADDR !== 13'h0 || RAM_DIN !== 8'h0 ||
            CPU_DOUT !== 16'h0 || dbg_state !== 3'(ST_IDLE)) begin
            n_fail++;
            $display("FAIL reset_values: got ndtack %b we %b addr %h din %h dout %h state %0d, exp 1 0 0 0 0 0",
                     nDTACK, RAM_WE, RAM_ADDR, RAM_DIN, CPU_DOUT, dbg_state);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (nDTACK !== 1'b1 || RAM_WE !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got ndtack %b we %b, exp 1 0", nDTACK, RAM_WE);
        end
    endtask

    task automatic test_word_write;
        do_access(1'b0, 1'b0, 1'b0, 12'h123, 16'hBEEF, 0, "word_write");
    endtask

    task automatic test_byte_write;
        do_access(1'b0, 1'b1, 1'b0, 12'h123, 16'h12AB, 0, "byte_write");
        n_cmp++;
        if (phys_mem[13'h0246] !== 8'hBE) begin
            n_fail++;
            $display("FAIL byte_write_hi_kept: got %h, exp be", phys_mem[13'h0246]);
        end
    endtask

    task automatic test_readback;
        do_access(1'b0, 1'b0, 1'b0, 12'h123, 16'h5AC3, 0, "rb_prep");
        do_access(1'b1, 1'b0, 1'b0, 12'h123, 16'h0000, 0, "readback");
    endtask

    task automatic test_video_priority;
        do_access(1'b0, 1'b0, 1'b0, 12'h0A5, 16'hC0DE, 3, "video_priority");
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic        rw;
            logic        uds_n;
            logic        lds_n;
            logic [11:0] a;
            int          st;
            int          sel;
            rw  = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 2);
            uds_n = (sel == 2);
            lds_n = (sel == 1);
            a   = 12'($urandom);
            st  = $urandom_range(0, 3);
`ifdef PAL_READBACK_EN
            if (rw) a = words[$urandom_range(0, words.size() - 1)];
`else
            if (rw) st = 0;
`endif
            do_access(rw, uds_n, lds_n, a, 16'($urandom), st, "random");
        end
    endtask

    task automatic test_reset_mid_write;
        @(negedge clk);
        PAL_CS = 1'b1; nAS = 1'b0; RW = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
        CPU_ADDR = 12'h123; CPU_DIN = 16'h7711;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (dbg_state !== 3'(ST_LO) || RAM_WE !== 1'b1 || RAM_ADDR !== 13'h0246 || RAM_DIN !== 8'h77) begin
            n_fail++;
            $display("FAIL rst_mid_hi_write: got state %0d we %b addr %h din %h, exp %0d 1 0246 77",
                     dbg_state, RAM_WE, RAM_ADDR, RAM_DIN, 3'(ST_LO));
        end
        reset = 1'b1; nAS = 1'b1; PAL_CS = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (RAM_WE !== 1'b0 || nDTACK !== 1'b1 || dbg_state !== 3'(ST_IDLE)) begin
            n_fail++;
            $display("FAIL rst_mid_abort: got we %b ndtack %b state %0d, exp 0 1 %0d",
                     RAM_WE, nDTACK, dbg_state, 3'(ST_IDLE));
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (RAM_WE !== 1'b0 || nDTACK !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_mid_quiet[%0d]: got we %b ndtack %b, exp 0 1", k, RAM_WE, nDTACK);
            end
        end
        model_mem[int'(13'h0246)] = 8'h77;
    endtask

    task automatic test_memory_image;
        int bad;
        bad = 0;
        foreach (model_mem[k]) begin
            if (phys_mem[13'(k)] !== model_mem[k]) begin
                if (bad < 4) $display("  byte %h: ram %h model %h", k, phys_mem[13'(k)], model_mem[k]);
                bad++;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL memory_image: got %0d differing bytes, exp 0", bad);
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_word_write();
        test_byte_write();
        test_readback();
        test_video_priority();
        test_random();
        test_reset_mid_write();
        test_memory_image();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
